// File: rtl/pulse_bram_arbiter_if.sv
// Purpose: one requester's command/read-return bundle for the pulse BRAM arbiter.
// Latency: none; this is only a wiring bundle.
// Backpressure: the requester holds req and its payload stable until gnt is seen high.
// Ports: req/we/lock/addr/wdata (requester -> arbiter),
//        gnt/rvalid/rdata (arbiter -> requester).
interface pulse_bram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/pulse_bram_arbiter.sv
// Purpose: round-robin arbiter with RMW lock for the single pulse-accumulation BRAM port.
// Latency: gnt is combinational; the BRAM port is registered (1 cycle); rvalid comes 1+RD_LATENCY edges after accept.
// Backpressure: a requester keeps req high until gnt; a locked owner excludes the other requester.
// Ports: clk, rst (sync, active high); m0/m1 requester bundles (slave side);
//        bram_addr/bram_data_in/bram_we/ena registered BRAM drive, bram_data_out read data;
//        lock_err one-cycle strobe when a lock is forcibly released by timeout.
module pulse_bram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_bram_arbiter_if.slave  m0,
  pulse_bram_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic [DATA_W-1:0]    bram_data_in,
  output logic                 bram_we,
  output logic                 ena,
  input  logic [DATA_W-1:0]    bram_data_out,
  output logic                 lock_err
);

  localparam int PIPE_D = 1 + RD_LATENCY;
  localparam int CNT_W  = $clog2(LOCK_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic                lock_err_q, lock_err_d;
  logic                ena_q, ena_d;
  logic                we_q, we_d;
  logic                tag_q, tag_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [PIPE_D-1:0]   pv_q, pv_d;
  logic [PIPE_D-1:0]   pt_q, pt_d;
  logic [DATA_W-1:0]   rd0_q, rd0_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;

  logic                gnt0, gnt1, acc, sel, sel_we, sel_lock;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                rv0, rv1;

  // Grant: in IDLE a tie goes to the requester that did not win last time;
  // while locked only the owner can be granted. Nothing is granted in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          gnt0 = m0.req && (!m1.req || last_gnt_q);
          gnt1 = m1.req && (!m0.req || !last_gnt_q);
        end
        LOCK0:   gnt0 = m0.req;
        LOCK1:   gnt1 = m1.req;
        default: ;
      endcase
    end
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  assign acc       = gnt0 | gnt1;
  assign sel       = gnt1;
  assign sel_we    = sel ? m1.we    : m0.we;
  assign sel_lock  = sel ? m1.lock  : m0.lock;
  assign sel_addr  = sel ? m1.addr  : m0.addr;
  assign sel_wdata = sel ? m1.wdata : m0.wdata;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    lock_err_d = 1'b0;

    // The port is driven for exactly one cycle per accept; addr/data hold otherwise.
    ena_d  = acc;
    we_d   = acc && sel_we;
    tag_d  = acc ? sel       : tag_q;
    addr_d = acc ? sel_addr  : addr_q;
    wdat_d = acc ? sel_wdata : wdat_q;

    case (state_q)
      IDLE: begin
        // Round-robin pointer only moves when both competed.
        if (m0.req && m1.req) last_gnt_d = sel;
        if (acc && sel_lock) begin
          state_d    = sel ? LOCK1 : LOCK0;
          lock_cnt_d = '0;
        end
      end
      LOCK0, LOCK1: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (acc && !sel_lock) begin
          // Voluntary release wins over a timeout on the same edge.
          state_d    = IDLE;
          last_gnt_d = sel;
        end else if (lock_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          // Forced release; pointing last_gnt at the owner hands the next tie away.
          state_d    = IDLE;
          lock_err_d = 1'b1;
          last_gnt_d = (state_q == LOCK1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-return tracking starts from the registered port, so the tail of the
  // pipe lines up with bram_data_out for the tagged read.
  always_comb begin
    pv_d = {pv_q[PIPE_D-2:0], ena_q && !we_q};
    pt_d = {pt_q[PIPE_D-2:0], tag_q};
  end

  assign rv0 = pv_q[PIPE_D-1] && !pt_q[PIPE_D-1];
  assign rv1 = pv_q[PIPE_D-1] &&  pt_q[PIPE_D-1];

  // Each requester's rdata passes BRAM data through on its strobe and holds otherwise.
  always_comb begin
    rd0_d = rv0 ? bram_data_out : rd0_q;
    rd1_d = rv1 ? bram_data_out : rd1_q;
  end

  assign m0.rvalid = rv0;
  assign m1.rvalid = rv1;
  assign m0.rdata  = rv0 ? bram_data_out : rd0_q;
  assign m1.rdata  = rv1 ? bram_data_out : rd1_q;

  assign ena          = ena_q;
  assign bram_we      = we_q;
  assign bram_addr    = addr_q;
  assign bram_data_in = wdat_q;
  assign lock_err     = lock_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
      ena_q      <= 1'b0;
      we_q       <= 1'b0;
      tag_q      <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      pv_q       <= '0;
      pt_q       <= '0;
      rd0_q      <= '0;
      rd1_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      lock_err_q <= lock_err_d;
      ena_q      <= ena_d;
      we_q       <= we_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      pv_q       <= pv_d;
      pt_q       <= pt_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
    end
  end

endmodule

// File: tb/tb_pulse_bram_arbiter.sv
// Purpose: self-checking bench for pulse_bram_arbiter; instance A uses RD_LATENCY=1, instance B uses RD_LATENCY=2.
// Latency: read expectations are due 2+RD_LATENCY tb cycles after the drive cycle.
// Backpressure: requesters hold req and payload until granted, as a real requester would.
module tb_pulse_bram_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
  pulse_bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
  pulse_bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  pulse_bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din, a_dout, b_dout;
  logic          a_we, b_we, a_ena, b_ena, a_err, b_err;

  pulse_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .m0(a0), .m1(a1),
    .bram_addr(a_addr), .bram_data_in(a_din), .bram_we(a_we), .ena(a_ena),
    .bram_data_out(a_dout), .lock_err(a_err));

  pulse_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2), .LOCK_TIMEOUT(TMO)) dut_l2 (
    .clk(clk), .rst(rst), .m0(b0), .m1(b1),
    .bram_addr(b_addr), .bram_data_in(b_din), .bram_we(b_we), .ena(b_ena),
    .bram_data_out(b_dout), .lock_err(b_err));

  function automatic logic [31:0] pat(input int i);
    if (i == 4) return 32'h3F59AD43;  // word at byte address 0x10
    return 32'h3F80_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // BRAM models: memory reads at the edge that samples the port, then RD_LATENCY output stages.
  logic          init_mem = 1'b1;
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] pa [2];
  logic [DW-1:0] pb [3];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= pat(i);
        mem_b[i] <= pat(i);
      end
    end else begin
      if (a_ena) begin
        if (a_we) mem_a[a_addr[9:2]] <= a_din;
        else      pa[0] <= mem_a[a_addr[9:2]];
      end
      if (b_ena) begin
        if (b_we) mem_b[b_addr[9:2]] <= b_din;
        else      pb[0] <= mem_b[b_addr[9:2]];
      end
    end
    pa[1] <= pa[0];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign a_dout = pa[1];
  assign b_dout = pb[2];

  // Reference memory contents as seen by accepted commands.
  logic [DW-1:0] ref_a [256];
  logic [DW-1:0] ref_b [256];

  int cyc = 0;
  logic rst_p = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_p <= rst;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb [4][$];
  logic [31:0] held [4] = '{default: '0};
  logic [3:0]  rv;
  logic [31:0] rd [4];

  always_comb begin
    rv    = {b1.rvalid, b0.rvalid, a1.rvalid, a0.rvalid};
    rd[0] = a0.rdata;
    rd[1] = a1.rdata;
    rd[2] = b0.rdata;
    rd[3] = b1.rdata;
  end

  // Scoreboard: each rvalid pops the oldest expectation for that requester and
  // must land on its due cycle; between strobes rdata must hold the last value.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (rst_p) begin
        held[k] = '0;
        chk($sformatf("rdata%0d in reset", k), rd[k], 0);
      end else if (rv[k]) begin
        if (sb[k].size() == 0) begin
          chk($sformatf("rvalid%0d unexpected", k), 1, 0);
        end else begin
          e = sb[k].pop_front();
          chk($sformatf("rvalid%0d cycle", k), cyc, e.due);
          chk($sformatf("rdata%0d", k), rd[k], e.dat);
          held[k] = e.dat;
        end
      end else begin
        chk($sformatf("rdata%0d hold", k), rd[k], held[k]);
      end
    end
  end

  task automatic set_m(input int k, input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [31:0] wd);
    case (k)
      0: begin a0.req = req; a0.we = we; a0.lock = lock; a0.addr = addr; a0.wdata = wd; end
      1: begin a1.req = req; a1.we = we; a1.lock = lock; a1.addr = addr; a1.wdata = wd; end
      2: begin b0.req = req; b0.we = we; b0.lock = lock; b0.addr = addr; b0.wdata = wd; end
      default: begin b1.req = req; b1.we = we; b1.lock = lock; b1.addr = addr; b1.wdata = wd; end
    endcase
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++) set_m(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic g [4];
  int   drv;

  // Called at a negedge after inputs are set: records grants, books accepted
  // commands into the reference model, and advances to the next negedge.
  task automatic cycle();
    logic        wv [4];
    logic [31:0] av [4];
    logic [31:0] dv [4];
    #1;
    drv  = cyc;
    g[0] = a0.gnt; g[1] = a1.gnt; g[2] = b0.gnt; g[3] = b1.gnt;
    wv[0] = a0.we; wv[1] = a1.we; wv[2] = b0.we; wv[3] = b1.we;
    av[0] = a0.addr; av[1] = a1.addr; av[2] = b0.addr; av[3] = b1.addr;
    dv[0] = a0.wdata; dv[1] = a1.wdata; dv[2] = b0.wdata; dv[3] = b1.wdata;
    chk("A single grant", a0.gnt & a1.gnt, 0);
    for (int k = 0; k < 4; k++) begin
      if (g[k]) begin
        if (wv[k]) begin
          if (k < 2) ref_a[av[k][9:2]] = dv[k];
          else       ref_b[av[k][9:2]] = dv[k];
        end else if (k < 2) begin
          sb[k].push_back('{drv + 3, ref_a[av[k][9:2]]});
        end else begin
          sb[k].push_back('{drv + 4, ref_b[av[k][9:2]]});
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ena"}, a_ena, 0);
    chk({tag, " bram_we"}, a_we, 0);
    chk({tag, " bram_addr"}, a_addr, 0);
    chk({tag, " bram_data_in"}, a_din, 0);
    chk({tag, " lock_err"}, a_err, 0);
    chk({tag, " m0_gnt"}, a0.gnt, 0);
    chk({tag, " m1_gnt"}, a1.gnt, 0);
    chk({tag, " m0_rvalid"}, a0.rvalid, 0);
    chk({tag, " m1_rvalid"}, a1.rvalid, 0);
    chk({tag, " m0_rdata"}, a0.rdata, 0);
    chk({tag, " m1_rdata"}, a1.rdata, 0);
  endtask

  int cl;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_a[i] = pat(i);
      ref_b[i] = pat(i);
    end
    idle_all();
    // Requests held high in reset: grants must still be suppressed.
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    idle_all();

    // Single m0 read of 0x10.
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    cycle();
    chk("t1 m0_gnt", g[0], 1);
    chk("t1 m1_gnt", g[1], 0);
    chk("t1 ena", a_ena, 1);
    chk("t1 bram_we", a_we, 0);
    chk("t1 bram_addr", a_addr, 32'h10);
    idle_all();
    cycle();
    chk("t1 ena drop", a_ena, 0);
    chk("t1 addr hold", a_addr, 32'h10);
    repeat (4) cycle();

    // Both requesting reads every cycle: strict alternation starting with m0.
    for (int i = 0; i < 6; i++) begin
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h40 + 32'(8 * i), 32'h0);
      set_m(1, 1'b1, 1'b0, 1'b0, 32'h44 + 32'(8 * i), 32'h0);
      cycle();
      chk("t2 m0_gnt", g[0], (i % 2) == 0);
      chk("t2 m1_gnt", g[1], (i % 2) == 1);
    end
    idle_all();
    repeat (4) cycle();

    // Locked RMW on 0x20 while m1 waits.
    set_m(0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    cycle();
    chk("t3 lock m0_gnt", g[0], 1);
    chk("t3 lock m1_gnt", g[1], 0);
    set_m(0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
    cycle();
    chk("t3 wait m1_gnt", g[1], 0);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h4049_0FDB);
    cycle();
    chk("t3 write m0_gnt", g[0], 1);
    chk("t3 write m1_gnt", g[1], 0);
    chk("t3 bram_we", a_we, 1);
    chk("t3 bram_data_in", a_din, 32'h4049_0FDB);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    chk("t3 m1 after release", g[1], 1);
    idle_all();
    repeat (4) cycle();

    // Lock timeout: m0 locks then goes quiet; m1 keeps requesting.
    set_m(0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0);
    cycle();
    chk("t4 lock m0_gnt", g[0], 1);
    cl = drv;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h34, 32'h0);
    for (int i = 0; i < 80; i++) begin
      cycle();
      chk("t4 m1_gnt", g[1], drv >= cl + TMO + 1);
      chk("t4 lock_err", a_err, cyc == cl + TMO + 1);
    end
    idle_all();
    repeat (4) cycle();

    // Reset one cycle after an m1 read is accepted.
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    cycle();
    chk("t5 m1_gnt", g[1], 1);
    sb[1].delete();
    rst = 1'b1;
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h18, 32'h0);
    @(negedge clk);
    #1;
    check_zero("t5 reset");
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5 no m1_rvalid", a1.rvalid, 0);
    end
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h18, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h1C, 32'h0);
    cycle();
    chk("t5 tie m0_gnt", g[0], 1);
    chk("t5 tie m1_gnt", g[1], 0);
    idle_all();
    repeat (4) cycle();

    // RD_LATENCY=2 instance: four back-to-back m1 reads.
    for (int i = 0; i < 4; i++) begin
      set_m(3, 1'b1, 1'b0, 1'b0, 32'h80 + 32'(4 * i), 32'h0);
      cycle();
      chk("t6 m1_gnt", g[3], 1);
    end
    idle_all();
    repeat (8) cycle();

    for (int k = 0; k < 4; k++) chk($sformatf("drain q%0d", k), sb[k].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
